// File: rtl/icache_fifo_v2_if.sv
// Handshake/data bundle between an icache queue producer/consumer and its FIFO.
interface icache_fifo_v2_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                  flush;
    logic                  wr_ena;
    logic [DATA_WIDTH-1:0] din;
    logic                  rd_ena;
    logic                  err_clr;
    logic [DATA_WIDTH-1:0] dout;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [CW-1:0]         count;
    logic                  overflow;
    logic                  underflow;

    // Producer/consumer side: drives requests, observes status.
    modport master (
        output flush, wr_ena, din, rd_ena, err_clr,
        input  dout, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    // FIFO side.
    modport slave (
        input  flush, wr_ena, din, rd_ena, err_clr,
        output dout, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/icache_fifo_v2.sv
// Any-depth first-word-fall-through FIFO with occupancy, thresholds,
// synchronous flush and sticky overflow/underflow flags.
module icache_fifo_v2 #(
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 4,
    parameter int AFULL_THRESH  = DEPTH - 1,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic               clk,
    input  logic               rst,
    icache_fifo_v2_if.slave    bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic full_s, empty_s;
    logic wr_acc_s, rd_acc_s, wr_rej_s, rd_rej_s;

    // Pointers wrap at DEPTH-1 explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return {PW{1'b0}};
        end else begin
            return p + PW'(1);
        end
    endfunction

    // Status decode and accept/reject from start-of-cycle state; flush masks everything.
    always_comb begin
        full_s   = (count_q == CW'(DEPTH));
        empty_s  = (count_q == {CW{1'b0}});
        wr_acc_s = bus.wr_ena && !full_s  && !bus.flush;
        rd_acc_s = bus.rd_ena && !empty_s && !bus.flush;
        wr_rej_s = bus.wr_ena &&  full_s  && !bus.flush;
        rd_rej_s = bus.rd_ena &&  empty_s && !bus.flush;
    end

    // Next-state: storage, pointers, occupancy and sticky error flags.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (bus.flush) begin
            wr_ptr_d = {PW{1'b0}};
            rd_ptr_d = {PW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (wr_acc_s) begin
                mem_d[wr_ptr_q] = bus.din;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (rd_acc_s) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({wr_acc_s, rd_acc_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end

        // A new error in the clearing cycle wins over err_clr.
        if (wr_rej_s) begin
            overflow_d = 1'b1;
        end else if (bus.err_clr) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
        if (rd_rej_s) begin
            underflow_d = 1'b1;
        end else if (bus.err_clr) begin
            underflow_d = 1'b0;
        end else begin
            underflow_d = underflow_q;
        end
    end

    // State registers with asynchronous reset; memory is cleared so dout reads 0 after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DATA_WIDTH{1'b0}};
            end
            wr_ptr_q    <= {PW{1'b0}};
            rd_ptr_q    <= {PW{1'b0}};
            count_q     <= {CW{1'b0}};
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.dout         = mem_q[rd_ptr_q];
    assign bus.full         = full_s;
    assign bus.empty        = empty_s;
    assign bus.almost_full  = (count_q >= CW'(AFULL_THRESH));
    assign bus.almost_empty = (count_q <= CW'(AEMPTY_THRESH));
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_icache_fifo_v2.sv
// Bench for icache_fifo_v2 (DEPTH=5, W=8): vector table, corner sequences, random vs queue model.
module tb_icache_fifo_v2;
    localparam int W = 8;
    localparam int D = 5;

    logic clk;
    logic rst;

    icache_fifo_v2_if #(.DATA_WIDTH(W), .DEPTH(D)) bus ();

    icache_fifo_v2 #(
        .DATA_WIDTH(W), .DEPTH(D), .AFULL_THRESH(4), .AEMPTY_THRESH(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    // Reference model: a plain queue plus sticky flags.
    logic [W-1:0] mq[$];
    bit           m_ovf;
    bit           m_unf;

    typedef struct {
        bit           fl;
        bit           wr;
        logic [W-1:0] din;
        bit           rd;
        bit           clr;
        int           cnt;
        logic [W-1:0] dout;
        bit           full;
        bit           empty;
        bit           af;
        bit           ae;
        bit           ovf;
        bit           unf;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        int n;
        n = mq.size();
        chk("count", 32'(bus.count), 32'(n));
        chk("full", 32'(bus.full), 32'(n == D));
        chk("empty", 32'(bus.empty), 32'(n == 0));
        chk("almost_full", 32'(bus.almost_full), 32'(n >= 4));
        chk("almost_empty", 32'(bus.almost_empty), 32'(n <= 1));
        chk("overflow", 32'(bus.overflow), 32'(m_ovf));
        chk("underflow", 32'(bus.underflow), 32'(m_unf));
        if (n > 0) begin
            chk("dout", 32'(bus.dout), 32'(mq[0]));
        end
    endtask

    task automatic step(input bit fl, input bit wr, input logic [W-1:0] d, input bit rd, input bit clr);
        int  n;
        bit  ovs;
        bit  uns;
        bus.flush   = fl;
        bus.wr_ena  = wr;
        bus.din     = d;
        bus.rd_ena  = rd;
        bus.err_clr = clr;
        @(posedge clk);
        #1;
        n   = mq.size();
        ovs = !fl && wr && (n == D);
        uns = !fl && rd && (n == 0);
        m_ovf = ovs ? 1'b1 : (clr ? 1'b0 : m_ovf);
        m_unf = uns ? 1'b1 : (clr ? 1'b0 : m_unf);
        if (fl) begin
            mq.delete();
        end else begin
            if (rd && n > 0) void'(mq.pop_front());
            if (wr && n < D) mq.push_back(d);
        end
        bus.flush   = 1'b0;
        bus.wr_ena  = 1'b0;
        bus.rd_ena  = 1'b0;
        bus.err_clr = 1'b0;
        check_model();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_dout"}, 32'(bus.dout), 32'h0);
        chk({tag, "_full"}, 32'(bus.full), 32'h0);
        chk({tag, "_empty"}, 32'(bus.empty), 32'h1);
        chk({tag, "_afull"}, 32'(bus.almost_full), 32'h0);
        chk({tag, "_aempty"}, 32'(bus.almost_empty), 32'h1);
        chk({tag, "_count"}, 32'(bus.count), 32'h0);
        chk({tag, "_ovf"}, 32'(bus.overflow), 32'h0);
        chk({tag, "_unf"}, 32'(bus.underflow), 32'h0);
    endtask

    function automatic vec_t mk(input bit wr, input logic [W-1:0] d, input bit rd, input bit clr,
                                input int cnt, input logic [W-1:0] dout, input bit full,
                                input bit empty, input bit af, input bit ae, input bit ovf,
                                input bit unf);
        vec_t v;
        v.fl = 1'b0; v.wr = wr; v.din = d; v.rd = rd; v.clr = clr;
        v.cnt = cnt; v.dout = dout; v.full = full; v.empty = empty;
        v.af = af; v.ae = ae; v.ovf = ovf; v.unf = unf;
        return v;
    endfunction

    initial begin
        n_vec = 0;
        n_err = 0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        rst         = 1'b1;
        bus.flush   = 1'b0;
        bus.wr_ena  = 1'b0;
        bus.din     = 8'h00;
        bus.rd_ena  = 1'b0;
        bus.err_clr = 1'b0;

        //            wr  din    rd clr cnt dout  full emp af ae ovf unf
        tbl[0]  = mk(1, 8'h11, 0, 0, 1, 8'h11, 0, 0, 0, 1, 0, 0);
        tbl[1]  = mk(1, 8'h22, 0, 0, 2, 8'h11, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(1, 8'h33, 0, 0, 3, 8'h11, 0, 0, 0, 0, 0, 0);
        tbl[3]  = mk(1, 8'h44, 0, 0, 4, 8'h11, 0, 0, 1, 0, 0, 0);
        tbl[4]  = mk(1, 8'h55, 0, 0, 5, 8'h11, 1, 0, 1, 0, 0, 0);
        tbl[5]  = mk(0, 8'h00, 1, 0, 4, 8'h22, 0, 0, 1, 0, 0, 0);
        tbl[6]  = mk(0, 8'h00, 1, 0, 3, 8'h33, 0, 0, 0, 0, 0, 0);
        tbl[7]  = mk(0, 8'h00, 1, 0, 2, 8'h44, 0, 0, 0, 0, 0, 0);
        tbl[8]  = mk(0, 8'h00, 1, 0, 1, 8'h55, 0, 0, 0, 1, 0, 0);
        tbl[9]  = mk(0, 8'h00, 1, 0, 0, 8'h00, 0, 1, 0, 1, 0, 0);
        tbl[10] = mk(0, 8'h00, 1, 0, 0, 8'h00, 0, 1, 0, 1, 0, 1);
        tbl[11] = mk(0, 8'h00, 0, 1, 0, 8'h00, 0, 1, 0, 1, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // Fill/drain table; the running model is checked alongside the fixed expectations.
        foreach (tbl[i]) begin
            step(tbl[i].fl, tbl[i].wr, tbl[i].din, tbl[i].rd, tbl[i].clr);
            chk($sformatf("tbl%0d_count", i), 32'(bus.count), 32'(tbl[i].cnt));
            chk($sformatf("tbl%0d_full", i), 32'(bus.full), 32'(tbl[i].full));
            chk($sformatf("tbl%0d_empty", i), 32'(bus.empty), 32'(tbl[i].empty));
            chk($sformatf("tbl%0d_af", i), 32'(bus.almost_full), 32'(tbl[i].af));
            chk($sformatf("tbl%0d_ae", i), 32'(bus.almost_empty), 32'(tbl[i].ae));
            chk($sformatf("tbl%0d_ovf", i), 32'(bus.overflow), 32'(tbl[i].ovf));
            chk($sformatf("tbl%0d_unf", i), 32'(bus.underflow), 32'(tbl[i].unf));
            if (tbl[i].cnt > 0) begin
                chk($sformatf("tbl%0d_dout", i), 32'(bus.dout), 32'(tbl[i].dout));
            end
        end

        // Wrap: preload 2, then 12 simultaneous write/read cycles.
        step(0, 1, 8'hA0, 0, 0);
        step(0, 1, 8'hA1, 0, 0);
        for (int i = 0; i < 12; i++) begin
            step(0, 1, 8'(8'hB0 + i), 1, 0);
            chk("wrap_count", 32'(bus.count), 32'd2);
        end
        chk("wrap_head", 32'(bus.dout), 32'hBA);
        chk("wrap_ovf", 32'(bus.overflow), 32'h0);
        chk("wrap_unf", 32'(bus.underflow), 32'h0);

        // Full with write+read: read wins, write dropped, overflow set; then clear.
        step(0, 1, 8'hC0, 0, 0);
        step(0, 1, 8'hC1, 0, 0);
        step(0, 1, 8'hC2, 0, 0);
        chk("fill_full", 32'(bus.full), 32'h1);
        step(0, 1, 8'hEE, 1, 0);
        chk("fullrw_count", 32'(bus.count), 32'd4);
        chk("fullrw_ovf", 32'(bus.overflow), 32'h1);
        step(0, 0, 8'h00, 0, 1);
        chk("errclr_ovf", 32'(bus.overflow), 32'h0);

        // Drain, then empty read+write: underflow, and the written value appears.
        while (mq.size() > 0) step(0, 0, 8'h00, 1, 0);
        step(0, 1, 8'hA5, 1, 0);
        chk("emptyrw_unf", 32'(bus.underflow), 32'h1);
        chk("emptyrw_count", 32'(bus.count), 32'd1);
        chk("emptyrw_dout", 32'(bus.dout), 32'hA5);
        step(0, 0, 8'h00, 1, 0);
        step(0, 0, 8'h00, 1, 1);
        chk("clr_vs_set_unf", 32'(bus.underflow), 32'h1);

        // Flush with count 3 beats same-cycle write and read.
        step(0, 1, 8'h01, 0, 0);
        step(0, 1, 8'h02, 0, 0);
        step(0, 1, 8'h03, 0, 0);
        step(1, 1, 8'h04, 1, 0);
        chk("flush_count", 32'(bus.count), 32'd0);
        chk("flush_empty", 32'(bus.empty), 32'h1);
        chk("flush_unf_kept", 32'(bus.underflow), 32'h1);
        chk("flush_ovf_kept", 32'(bus.overflow), 32'h0);
        step(0, 1, 8'h77, 0, 0);
        chk("postflush_dout", 32'(bus.dout), 32'h77);

        // Asynchronous reset mid-stream with count 4.
        step(0, 1, 8'h81, 0, 0);
        step(0, 1, 8'h82, 0, 0);
        step(0, 1, 8'h83, 0, 0);
        chk("prerst_count", 32'(bus.count), 32'd4);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        mq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(0, 1, 8'h91, 0, 0);
        chk("postrst_dout", 32'(bus.dout), 32'h91);
        step(0, 1, 8'h92, 0, 0);

        // Random traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 29) == 0,
                 $urandom_range(0, 1) == 1,
                 8'($urandom),
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 15) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/icache_fifo_v2.md
# icache_fifo_v2

Parametrised synchronous FIFO for the icache refill/request paths, replacing the fixed power-of-two buffer with one that supports any depth, occupancy reporting, programmable almost-full/almost-empty thresholds, synchronous flush and sticky overflow/underflow error flags. Data is first-word-fall-through: the head entry is always presented on `dout` while the FIFO is non-empty. It sits between the icache miss logic and the fetch/refill consumers, one instance per queue.

## Interface
- `DATA_WIDTH`, 8, entry width in bits (≥1).
- `DEPTH`, 4, number of entries (≥2, any integer, not restricted to powers of two).
- `AFULL_THRESH`, DEPTH-1, `almost_full` asserts when count ≥ this value (1..DEPTH).
- `AEMPTY_THRESH`, 1, `almost_empty` asserts when count ≤ this value (0..DEPTH-1).
- `CW` (derived, localparam), $clog2(DEPTH+1), width of `count`.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: reset, asynchronous and active-high.
- `flush` in 1: synchronous clear of occupancy.
- `wr_ena` in 1: write request.
- `din` in DATA_WIDTH: write data.
- `rd_ena` in 1: read (pop) request.
- `dout` out DATA_WIDTH: head entry (FWFT).
- `full` out 1: count == DEPTH.
- `empty` out 1: count == 0.
- `almost_full` out 1: count ≥ AFULL_THRESH.
- `almost_empty` out 1: count ≤ AEMPTY_THRESH.
- `count` out CW: current occupancy, 0..DEPTH.
- `overflow` out 1: sticky, write attempted while full.
- `underflow` out 1: sticky, read attempted while empty.
- `err_clr` in 1: clears both sticky error flags.

## Operation
- Storage: DEPTH × DATA_WIDTH register array; write pointer, read pointer (0..DEPTH-1) and count register.
- Pointers wrap explicitly: DEPTH-1 → 0 (no reliance on binary rollover).
- Write accepted iff `wr_ena && !full`; the entry is stored at wr_ptr and wr_ptr advances.
- Read accepted iff `rd_ena && !empty`; rd_ptr advances.
- Evaluation is against start-of-cycle state: when full, a write is rejected even if a read is accepted in the same cycle. When empty, a read is rejected even if a write occurs in the same cycle (no bypass).
- Count update: +1 (write only), −1 (read only), unchanged (both or neither accepted).
- `full`, `empty`, `almost_*` are combinational decodes of the registered count. `dout` = mem[rd_ptr], combinational from registers.
- Rejected write (`wr_ena && full`): data is dropped, state is unchanged, and `overflow` sets.
- Rejected read (`rd_ena && empty`): state is unchanged, `dout` holds, and `underflow` sets.
- `err_clr` clears both flags next edge. Error set in the same cycle as `err_clr` wins (flag stays 1).
- `flush`: next edge wr_ptr = rd_ptr = count = 0. It has priority over same-cycle writes and reads: neither is accepted and neither sets an error flag. Memory contents are not cleared. Sticky flags are unaffected by `flush`.
- Reset (async): pointers 0, count 0, all memory entries 0, overflow/underflow 0.

## Timing
- Reset values of outputs: `dout`=0, `full`=0, `empty`=1, `almost_full`=0, `almost_empty`=1, `count`=0, `overflow`=0, `underflow`=0.
- Write-to-dout latency: 1 cycle. A write into an empty FIFO at edge N makes `empty`=0 and `dout`=din after edge N.
- Read: `dout` shows the next entry after the accepting edge.
- Flags and count reflect an operation after the same edge that accepts it. No extra pipeline stage.
- `rst` assertion mid-operation returns all state to reset values immediately, independent of `clk`.
- Throughput: one write and one read per cycle, sustained, when neither full nor empty.

## Test plan
- Reset, then DEPTH=5, W=8: write 0x11..0x55 on 5 consecutive cycles -> count 1..5, `almost_full` at count 4, `full`=1 after the 5th write. Read 5 times -> `dout` 0x11,0x22,0x33,0x44,0x55 in order, then `empty`=1, count 0.
- DEPTH=5 wrap: 12 cycles of simultaneous write/read after preloading 2 entries -> count stays 2, data in order across the 4→0 pointer wrap, no error flags.
- Full with `wr_ena`+`rd_ena` same cycle -> read accepted, write dropped, count 5→4, `overflow`=1. Then `err_clr` -> `overflow`=0 the next cycle.
- Empty with `rd_ena`+`wr_ena` (din=0xA5) same cycle -> `underflow`=1, count 0→1, `dout`=0xA5 next cycle. `err_clr` asserted together with another empty read -> `underflow` stays 1.
- Count=3 and `flush` with `wr_ena`+`rd_ena` -> next cycle count 0, `empty`=1, no flag change. A subsequent write of 0x77 -> `dout`=0x77.
- Assert `rst` asynchronously mid-stream with count=4 -> all outputs at reset values before the next `clk` edge. After release, normal writes resume.
